// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM state encoding,
// default bus geometry and the register map used by bus masters.
package periph_bus_pkg;

    localparam int PERIPH_ADDR_W = 2;
    localparam int PERIPH_DATA_W = 16;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Peripheral register indices on the shared bus.
    localparam logic [PERIPH_ADDR_W-1:0] UART_REG_DATA   = 2'd0;
    localparam logic [PERIPH_ADDR_W-1:0] UART_REG_STATUS = 2'd1;
    localparam logic [PERIPH_ADDR_W-1:0] TIMER_REG_COUNT = 2'd2;
    localparam logic [PERIPH_ADDR_W-1:0] TIMER_REG_CTRL  = 2'd3;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: starting just after the last winner,
// returns the first asserted request index (wrapping modulo N_REQ).
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [IDX_W:0] sum_s;

    // Scan from farthest to nearest so the nearest asserted index overwrites last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        sum_s   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum_s = {1'b0, last} + (IDX_W + 1)'(k);
            if (sum_s >= (IDX_W + 1)'(N_REQ)) begin
                sum_s = sum_s - (IDX_W + 1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            if (req[sum_s[IDX_W-1:0]]) begin
                winner  = sum_s[IDX_W-1:0];
                any_req = 1'b1;
            end else begin
                winner  = winner;
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter for the shared peripheral register bus. Each grant is
// run as exactly one bus access (ACCESS) followed by a one-cycle ack (DONE).
// All bus outputs and acks come straight from flops.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = PERIPH_ADDR_W,
    parameter int DATA_W = PERIPH_DATA_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         reqValid,
    input  logic [N_REQ-1:0]         reqWr,
    input  logic [N_REQ*ADDR_W-1:0]  reqAddr,
    input  logic [N_REQ*DATA_W-1:0]  reqData,
    output logic [N_REQ-1:0]         respAck,
    output logic [DATA_W-1:0]        respData,
    output logic [ADDR_W-1:0]        busAddr,
    inout  wire  [DATA_W-1:0]        busData,
    output logic                     busEn,
    output logic                     busWr
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_e          state_r, next_state_s;
    logic [IDX_W-1:0]    win_r, win_s;
    logic [IDX_W-1:0]    last_r, last_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic [ADDR_W-1:0]   bus_addr_r, bus_addr_s;
    logic                bus_en_r, bus_en_s;
    logic                bus_wr_r, bus_wr_s;
    logic [N_REQ-1:0]    ack_r, ack_s;
    logic [DATA_W-1:0]   resp_data_r, resp_data_s;

    logic [IDX_W-1:0]    pick_s;
    logic                any_req_s;
    logic [ADDR_W-1:0]   addr_arr_s [N_REQ];
    logic [DATA_W-1:0]   data_arr_s [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_arr_s[i] = reqAddr[i*ADDR_W +: ADDR_W];
        assign data_arr_s[i] = reqData[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (reqValid),
        .last    (last_r),
        .winner  (pick_s),
        .any_req (any_req_s)
    );

    // Next-state and next-register values; bus strobes default inactive.
    always_comb begin
        next_state_s = state_r;
        win_s        = win_r;
        last_s       = last_r;
        data_s       = data_r;
        bus_addr_s   = bus_addr_r;
        bus_en_s     = 1'b0;
        bus_wr_s     = 1'b0;
        ack_s        = '0;
        resp_data_s  = resp_data_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    win_s        = pick_s;
                    data_s       = data_arr_s[pick_s];
                    bus_addr_s   = addr_arr_s[pick_s];
                    bus_en_s     = 1'b1;
                    bus_wr_s     = reqWr[pick_s];
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                last_s       = win_r;
                ack_s[win_r] = 1'b1;
                if (!bus_wr_r) begin
                    resp_data_s = busData;
                end else begin
                    resp_data_s = resp_data_r;
                end
                next_state_s = DONE;
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latched grant, round-robin pointer, bus outputs and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_r       <= '0;
            last_r      <= IDX_W'(N_REQ - 1);
            data_r      <= '0;
            bus_addr_r  <= '0;
            bus_en_r    <= 1'b0;
            bus_wr_r    <= 1'b0;
            ack_r       <= '0;
            resp_data_r <= '0;
        end else begin
            win_r       <= win_s;
            last_r      <= last_s;
            data_r      <= data_s;
            bus_addr_r  <= bus_addr_s;
            bus_en_r    <= bus_en_s;
            bus_wr_r    <= bus_wr_s;
            ack_r       <= ack_s;
            resp_data_r <= resp_data_s;
        end
    end

    // The arbiter only drives the data bus during a write access.
    assign busData  = bus_wr_r ? data_r : {DATA_W{1'bz}};
    assign busEn    = bus_en_r;
    assign busWr    = bus_wr_r;
    assign busAddr  = bus_addr_r;
    assign respAck  = ack_r;
    assign respData = resp_data_r;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: the driver pushes expected grants,
// a negedge monitor pops and checks them when the bus or ack is active.
module tb_periph_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 2;
    localparam int DW = 16;

    typedef struct {
        int          idx;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] resp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  resp_ack;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] bus_addr;
    wire  [DW-1:0] bus_data;
    logic          bus_en;
    logic          bus_wr;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    logic          pend = 1'b0;
    logic [N-1:0]  persist;

    // Slave model: register file; it also keeps the bus at 0 whenever the
    // arbiter must not drive, so any arbiter drive shows up as a change.
    logic [15:0]   mem [4];
    logic [15:0]   slave_drive_s;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .reqValid (req_valid),
        .reqWr    (req_wr),
        .reqAddr  (req_addr),
        .reqData  (req_data),
        .respAck  (resp_ack),
        .respData (resp_data),
        .busAddr  (bus_addr),
        .busData  (bus_data),
        .busEn    (bus_en),
        .busWr    (bus_wr)
    );

    assign slave_drive_s = bus_en ? mem[bus_addr] : 16'h0000;
    assign bus_data      = (bus_en && bus_wr) ? {16{1'bz}} : slave_drive_s;

    // Slave register file: reset contents, capture bus writes.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= 16'h0000;
            mem[1] <= 16'h0000;
            mem[2] <= 16'h00A5;
            mem[3] <= 16'h0000;
        end else if (bus_en && bus_wr) begin
            mem[bus_addr] <= bus_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare bus accesses and acks against the scoreboard front.
    always @(negedge clk) begin
        if (!rstn) begin
            if (pend) void'(sb.pop_front());
            pend = 1'b0;
        end else begin
            if (!(bus_en && bus_wr)) check("bus_not_driven", bus_data, slave_drive_s);
            if (bus_en) begin
                check("access_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check("acc_addr", 32'(bus_addr), 32'(sb[0].addr));
                    check("acc_wr", 32'(bus_wr), 32'(sb[0].wr));
                    if (sb[0].wr) check("acc_wdata", 32'(bus_data), 32'(sb[0].data));
                end
                pend = 1'b1;
            end else if (resp_ack != '0) begin
                check("ack_after_access", 32'(pend), 32'd1);
                check("ack_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check("ack_onehot", 32'(resp_ack), 32'd1 << sb[0].idx);
                    check("resp_data", 32'(resp_data), 32'(sb[0].resp));
                    void'(sb.pop_front());
                end
                pend = 1'b0;
            end else begin
                if (pend) check("ack_missing", 32'(resp_ack), 32'd1 << sb[0].idx);
                pend = 1'b0;
            end
        end
    end

    // One requester-side cycle: drop acked requests, re-raise persistent ones.
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (resp_ack[i]) req_valid[i] = 1'b0;
            else if (persist[i]) req_valid[i] = 1'b1;
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [1:0] a,
                           input logic [15:0] d, input logic [15:0] resp, input bit push);
        exp_t e;
        req_wr[i]             = wr;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
        req_valid[i]          = 1'b1;
        if (push) begin
            e.idx = i; e.wr = wr; e.addr = a; e.data = d; e.resp = resp;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            cyc();
            if (req_valid == '0 && sb.size() == 0) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        cyc();
    endtask

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        int acks;
        int n;
        logic [N-1:0] prev_ack;
        rstn = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0; persist = '0;

        // Reset state
        cyc(); cyc();
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_bus_wr", 32'(bus_wr), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_data", 32'(bus_data), 32'd0);
        check("rst_resp_ack", 32'(resp_ack), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        rstn = 1'b1;

        // Write: one access cycle, ack the cycle after
        cyc();
        set_req(0, 1'b1, 2'd1, 16'h0025, 16'h0000, 1'b1);
        cyc();
        check("wr_lat_en", 32'(bus_en), 32'd1);
        check("wr_lat_data", 32'(bus_data), 32'h0025);
        cyc();
        check("wr_lat_ack", 32'(resp_ack), 32'd1);
        check("wr_single_access", 32'(bus_en), 32'd0);
        drain();

        // Read, then a write that must leave respData alone
        set_req(1, 1'b0, 2'd2, 16'h0000, 16'h00A5, 1'b1);
        drain();
        check("rd_data", 32'(resp_data), 32'h00A5);
        set_req(0, 1'b1, 2'd0, 16'h0BEE, 16'h00A5, 1'b1);
        drain();
        check("rd_hold", 32'(resp_data), 32'h00A5);

        // Contention from reset: grants alternate 0,1,0,1,0,1
        rstn = 1'b0;
        req_valid = '0;
        cyc(); cyc();
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) set_req(0, 1'b1, 2'd0, 16'h1111, 16'h0000, 1'b1);
            else            set_req(1, 1'b1, 2'd3, 16'h3333, 16'h0000, 1'b1);
        end
        persist = 2'b11;
        rstn = 1'b1;
        acks = 0;
        prev_ack = '0;
        for (int c = 0; c < 60 && acks < 6; c++) begin
            cyc();
            if (resp_ack != '0) begin
                acks++;
                check("cont_alternate", 32'(resp_ack != prev_ack), 32'd1);
                prev_ack = resp_ack;
                if (acks == 5) persist = '0;
            end
        end
        check("cont_count", 32'(acks), 32'd6);
        drain();

        // Late arrival: req1 appears during req0's access and waits
        set_req(0, 1'b1, 2'd1, 16'h0A0A, 16'h0000, 1'b1);
        cyc();
        set_req(1, 1'b0, 2'd2, 16'h0000, 16'h00A5, 1'b1);
        req_data[15:0] = 16'hFFFF;
        check("late_held_data", 32'(bus_data), 32'h0A0A);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            n++;
            if (resp_ack[1]) break;
        end
        check("late_latency", 32'(n), 32'd4);
        drain();

        // Reset in the middle of an access
        set_req(0, 1'b1, 2'd0, 16'h5A5A, 16'h00A5, 1'b1);
        cyc();
        check("mid_rst_in_access", 32'(bus_en), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_bus_en", 32'(bus_en), 32'd0);
        check("mid_rst_bus_wr", 32'(bus_wr), 32'd0);
        check("mid_rst_bus_data", 32'(bus_data), 32'd0);
        check("mid_rst_ack", 32'(resp_ack), 32'd0);
        cyc();
        check("mid_rst_no_ack", 32'(resp_ack), 32'd0);
        set_req(0, 1'b1, 2'd0, 16'h5A5A, 16'h0000, 1'b1);
        set_req(1, 1'b0, 2'd2, 16'h0000, 16'h00A5, 1'b1);
        cyc();
        check("mid_rst_no_ack2", 32'(resp_ack), 32'd0);
        rstn = 1'b1;
        drain();
        check("post_rst_resp", 32'(resp_data), 32'h00A5);

        // Idle: bus and ack stay quiet
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("idle_quiet", {29'd0, bus_en, bus_wr, |resp_ack}, 32'd0);
            check("idle_bus", 32'(bus_data), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
